rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Shares the single-port instruction ROM macro between two burst read requesters: requester 0 is the AXI-side ROM wrapper, requester 1 is the boot/debug loader. It grants one requester at a time with round-robin priority and sequences the ROM address across the granted burst. It drives the ROM enable, read and address pins directly, and returns ROM data with a per-beat valid/ready handshake and zero-bubble streaming.

## Interface
Parameters:
- `ADDR_W`, default 12: ROM word-address width.
- `LEN_W`, default 4: burst length field width; the field carries beats minus 1.
- `DATA_W`, default `` `DATA_BITS `` (32): ROM data width.

Ports. The clock is `clk`. Reset is `rst`: asynchronous, active-low, one clock domain.
- `clk`  in  1  clock.
- `rst`  in  1  async active-low reset.
- `req_i[1:0]`  in  2  per-requester request level, held until granted.
- `addr0_i`, `addr1_i`  in  ADDR_W  burst start word address.
- `len0_i`, `len1_i`  in  LEN_W  beats minus 1.
- `gnt_o[1:0]`  out  2  one-cycle grant pulse.
- `rvalid_o[1:0]`  out  2  beat valid; only the owner's bit can be high.
- `rlast_o[1:0]`  out  2  final beat; qualified by `rvalid_o`.
- `rready_i[1:0]`  in  2  beat accept.
- `rdata_o`  out  DATA_W  ROM data, broadcast to both requesters.
- `ROM_out_i`  in  DATA_W  ROM data out; valid 1 cycle after the address.
- `ROM_en_o`  out  1  ROM enable.
- `ROM_read_o`  out  1  ROM read strobe; always equals `ROM_en_o`.
- `ROM_addr_o`  out  ADDR_W  ROM word address.

## Operation
- States are IDLE and BURST.
- Registered state: `owner` (1b), `base` (ADDR_W), `len` (LEN_W), `cnt` (LEN_W), `prio` (1b, the preferred requester).
- IDLE, no request: `ROM_en_o`=0, `ROM_addr_o`=0.
- IDLE, request present:
  - Winner is `prio` if `req_i[prio]`, otherwise the other requester.
  - Pulse `gnt_o[winner]`.
  - Latch `base`, `len`, `owner`; clear `cnt`.
  - Drive `ROM_en_o`=1 and `ROM_addr_o` = winner's `addr`, combinationally, in the same cycle.
  - Go to BURST.
- BURST:
  - `rvalid_o[owner]`=1 and `rdata_o`=`ROM_out_i`.
  - `rlast_o[owner]` = (`cnt`==`len`).
  - Beat handshake `hs` = `rvalid_o[owner]` & `rready_i[owner]`.
  - `ROM_addr_o` = `base` + `cnt` + `hs`, computed as ADDR_W-bit modular addition (0xFFF+1 wraps to 0x000).
  - `ROM_en_o`=1 throughout BURST.
  - On `hs`, `cnt` increments.
  - Without `hs`, the address re-presents the same word and the data holds stable.
- Last-beat handshake (`hs` & `rlast`):
  - `cnt` clears to 0.
  - `prio` is set to the inverse of `owner`.
  - Next state is IDLE, or as described under Configuration.
- A `req_i` deasserted mid-burst is ignored; the burst completes.
- `req_i` of the owner during its own burst is treated as a new request after the burst ends.
- `rdata_o` is always `ROM_out_i`; consumers qualify it by `rvalid_o`.

## Timing
- Reset values: all outputs 0; state IDLE; `prio`=0; `cnt`, `base`, `len`, `owner` all 0.
- Reset asserted mid-burst aborts the burst immediately. No `rlast_o` is issued.
- Latency: grant at cycle T; first `rvalid_o` at T+1.
- With `rready_i` held high, one beat per cycle: burst of N beats occupies T+1..T+N.
- Both requesters requesting in the same IDLE cycle: `prio` wins. Alternation is guaranteed under continuous contention.
- `gnt_o` is never high in BURST, except under `ROM_ARB_BACK2BACK_EN`.

## Configuration
- `ROM_ARB_BACK2BACK_EN` defined:
  - On the last-beat handshake, if any `req_i` is high, arbitration runs with the updated `prio` in the same cycle.
  - That cycle pulses `gnt_o`, drives `ROM_addr_o` = new winner's `addr`, and stays in BURST.
  - The new first beat appears the next cycle, so there is no idle bubble.
- Undefined: the last-beat handshake always returns to IDLE, giving a 1-cycle gap between bursts.

## Structure
- Shared package `rom_arb_pkg`:
  - `state_t` enum {IDLE, BURST}.
  - `ROM_ADDR_W`=12, `ROM_LEN_W`=4.
  - `req_id_t` (1b).
- One sub-module, `rom_arb_rr`: a combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: `winner`, `any`.
- The `prio` register stays in the top module.

## Test plan
- Reset then idle: all outputs 0. `req_i`=2'b01, `addr0_i`=0x010, `len0_i`=3 → `gnt_o`=01 with `ROM_addr_o`=0x010; beats at 0x010..0x013 on 4 consecutive cycles; `rlast_o[0]` on the 4th beat.
- Backpressure: `rready_i[0]` low for 2 cycles on beat 1 → `ROM_addr_o` holds at base+1, `rdata_o` stable, `cnt` unchanged; the burst resumes without loss.
- Simultaneous `req_i`=2'b11 from reset → requester 0 served first, then requester 1, then 0 again while both stay high.
- Wrap: `addr1_i`=0xFFE, `len1_i`=3 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-burst (`rst` low at beat 2) → all outputs 0 immediately; after release the next grant goes to requester 0.
- With `ROM_ARB_BACK2BACK_EN`: two pending requests → second `gnt_o` coincides with the first burst's last handshake, no idle cycle between `rvalid_o` streams.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and sizing for the instruction-ROM read arbiter.
// Also provides the default for `DATA_BITS when the build does not set it.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

package rom_arb_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_LEN_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rom_arb_rr.sv
// Combinational 2-way round-robin picker.
// The preferred requester wins when it requests; otherwise the other one does.
module rom_arb_rr
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    prio,
    output req_id_t    winner,
    output logic       any
);

    assign any    = |req;
    assign winner = req[prio] ? prio : ~prio;

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the single-port instruction ROM between the AXI wrapper (0) and the boot/debug loader (1).
// Optional macro ROM_ARB_BACK2BACK_EN: re-arbitrate on the last beat so bursts stream with no idle cycle.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int LEN_W  = ROM_LEN_W,
    parameter int DATA_W = `DATA_BITS
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [LEN_W-1:0]  len0_i,
    input  logic [LEN_W-1:0]  len1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [1:0]        rlast_o,
    input  logic [1:0]        rready_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [DATA_W-1:0] ROM_out_i,
    output logic              ROM_en_o,
    output logic              ROM_read_o,
    output logic [ADDR_W-1:0] ROM_addr_o
);

    state_t            r_state;
    req_id_t           r_owner;
    req_id_t           r_prio;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;

    logic              w_in_burst;
    logic              w_last;
    logic              w_hs;
    logic              w_done;
    logic              w_b2b;
    logic              w_grant;
    logic              w_any;
    req_id_t           w_winner;
    req_id_t           w_rr_prio;
    logic [ADDR_W-1:0] w_win_addr;
    logic [LEN_W-1:0]  w_win_len;

    assign w_in_burst = (r_state == BURST);
    assign w_last     = (r_cnt == r_len);
    assign w_hs       = w_in_burst & rready_i[r_owner];
    assign w_done     = w_hs & w_last;

    // In BURST the picker only matters on the last beat, where prio is about to become ~owner.
    assign w_rr_prio  = w_in_burst ? ~r_owner : r_prio;

    rom_arb_rr u_rr (
        .req    (req_i),
        .prio   (w_rr_prio),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_win_addr = w_winner ? addr1_i : addr0_i;
    assign w_win_len  = w_winner ? len1_i  : len0_i;

`ifdef ROM_ARB_BACK2BACK_EN
    assign w_b2b = w_done & w_any;
`else
    assign w_b2b = 1'b0;
`endif

    // Grant is suppressed while reset is held so every output reads 0 during reset.
    assign w_grant = rst & ((~w_in_burst & w_any) | w_b2b);

    always_comb begin
        gnt_o      = 2'b00;
        rvalid_o   = 2'b00;
        rlast_o    = 2'b00;
        ROM_en_o   = 1'b0;
        ROM_addr_o = '0;
        if (w_in_burst) begin
            rvalid_o[r_owner] = 1'b1;
            rlast_o[r_owner]  = w_last;
            ROM_en_o          = 1'b1;
            ROM_addr_o        = r_base + ADDR_W'(r_cnt) + ADDR_W'(w_hs);
        end
        if (w_grant) begin
            gnt_o[w_winner] = 1'b1;
            ROM_en_o        = 1'b1;
            ROM_addr_o      = w_win_addr;
        end
    end

    assign ROM_read_o = ROM_en_o;
    assign rdata_o    = ROM_out_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (!w_in_burst) begin
            if (w_any) begin
                r_owner <= w_winner;
                r_base  <= w_win_addr;
                r_len   <= w_win_len;
                r_cnt   <= '0;
                r_state <= BURST;
            end
        end else if (w_hs) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_prio <= ~r_owner;
                if (w_b2b) begin
                    r_owner <= w_winner;
                    r_base  <= w_win_addr;
                    r_len   <= w_win_len;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a one-cycle-latency ROM model.
// Back-to-back expectations follow ROM_ARB_BACK2BACK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [11:0] addr0_i, addr1_i;
    logic [3:0]  len0_i, len1_i;
    logic [1:0]  gnt_o, rvalid_o, rlast_o, rready_i;
    logic [31:0] rdata_o;
    logic [31:0] rom_q = 32'h0;
    logic        ROM_en_o, ROM_read_o;
    logic [11:0] ROM_addr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rom_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .addr0_i    (addr0_i),
        .addr1_i    (addr1_i),
        .len0_i     (len0_i),
        .len1_i     (len1_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rlast_o    (rlast_o),
        .rready_i   (rready_i),
        .rdata_o    (rdata_o),
        .ROM_out_i  (rom_q),
        .ROM_en_o   (ROM_en_o),
        .ROM_read_o (ROM_read_o),
        .ROM_addr_o (ROM_addr_o)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hA5, 4'h0, a, ~a[7:0]};
    endfunction

    always @(posedge clk) if (ROM_en_o) rom_q <= rom_word(ROM_addr_o);

    task automatic test_reset();
        rst = 1'b0; req_i = 2'b00; rready_i = 2'b11;
        addr0_i = '0; addr1_i = '0; len0_i = '0; len1_i = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({gnt_o, rvalid_o, rlast_o, ROM_en_o, ROM_read_o, ROM_addr_o} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rlast=%b en=%b rd=%b addr=%h, want all 0",
                     gnt_o, rvalid_o, rlast_o, ROM_en_o, ROM_read_o, ROM_addr_o);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({gnt_o, rvalid_o, rlast_o, ROM_en_o, ROM_read_o, ROM_addr_o} !== 20'h0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got gnt=%b rvalid=%b en=%b addr=%h, want all 0",
                     gnt_o, rvalid_o, ROM_en_o, ROM_addr_o);
        end
    endtask

    task automatic test_single();
        logic [11:0] a;
        @(posedge clk); #1 req_i = 2'b01; addr0_i = 12'h010; len0_i = 4'd3;
        @(negedge clk);
        tests_run++;
        if ({gnt_o, rvalid_o, ROM_en_o, ROM_read_o, ROM_addr_o} !== {2'b01, 2'b00, 1'b1, 1'b1, 12'h010}) begin
            tests_failed++;
            $display("FAIL single_grant: got gnt=%b rvalid=%b en=%b rd=%b addr=%h, want 01 00 1 1 010",
                     gnt_o, rvalid_o, ROM_en_o, ROM_read_o, ROM_addr_o);
        end
        @(posedge clk); #1 req_i = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 12'h010 + 12'(k);
            tests_run++;
            if ({gnt_o, rvalid_o, rlast_o, ROM_addr_o, rdata_o} !==
                {2'b00, 2'b01, (k == 3) ? 2'b01 : 2'b00, a + 12'h001, rom_word(a)}) begin
                tests_failed++;
                $display("FAIL single_beat%0d: got gnt=%b rvalid=%b rlast=%b addr=%h data=%h, want 00 01 %b %h %h",
                         k, gnt_o, rvalid_o, rlast_o, ROM_addr_o, rdata_o,
                         (k == 3) ? 2'b01 : 2'b00, a + 12'h001, rom_word(a));
            end
        end
        @(negedge clk);
        tests_run++;
        if ({gnt_o, rvalid_o, ROM_en_o, ROM_addr_o} !== 17'h0) begin
            tests_failed++;
            $display("FAIL single_gap: got gnt=%b rvalid=%b en=%b addr=%h, want all 0",
                     gnt_o, rvalid_o, ROM_en_o, ROM_addr_o);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] a;
        @(posedge clk); #1 req_i = 2'b10; addr1_i = 12'hFFE; len1_i = 4'd3;
        @(negedge clk);
        tests_run++;
        if ({gnt_o, ROM_en_o, ROM_addr_o} !== {2'b10, 1'b1, 12'hFFE}) begin
            tests_failed++;
            $display("FAIL wrap_grant: got gnt=%b en=%b addr=%h, want 10 1 ffe", gnt_o, ROM_en_o, ROM_addr_o);
        end
        @(posedge clk); #1 req_i = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 12'hFFE + 12'(k);
            tests_run++;
            if ({rvalid_o, rlast_o, ROM_addr_o, rdata_o} !==
                {2'b10, (k == 3) ? 2'b10 : 2'b00, a + 12'h001, rom_word(a)}) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d: got rvalid=%b rlast=%b addr=%h data=%h, want 10 %b %h %h",
                         k, rvalid_o, rlast_o, ROM_addr_o, rdata_o,
                         (k == 3) ? 2'b10 : 2'b00, a + 12'h001, rom_word(a));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1 req_i = 2'b01; addr0_i = 12'h100; len0_i = 4'd2;
        @(negedge clk);
        tests_run++;
        if ({gnt_o, ROM_addr_o} !== {2'b01, 12'h100}) begin
            tests_failed++;
            $display("FAIL bp_grant: got gnt=%b addr=%h, want 01 100", gnt_o, ROM_addr_o);
        end
        @(posedge clk); #1 req_i = 2'b00;
        @(negedge clk);
        tests_run++;
        if ({rvalid_o, rlast_o, ROM_addr_o, rdata_o} !== {2'b01, 2'b00, 12'h101, rom_word(12'h100)}) begin
            tests_failed++;
            $display("FAIL bp_beat0: got rvalid=%b rlast=%b addr=%h data=%h, want 01 00 101 %h",
                     rvalid_o, rlast_o, ROM_addr_o, rdata_o, rom_word(12'h100));
        end
        @(posedge clk); #1 rready_i = 2'b10;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            tests_run++;
            if ({rvalid_o, rlast_o, ROM_addr_o, rdata_o} !== {2'b01, 2'b00, 12'h101, rom_word(12'h101)}) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: got rvalid=%b rlast=%b addr=%h data=%h, want 01 00 101 %h",
                         s, rvalid_o, rlast_o, ROM_addr_o, rdata_o, rom_word(12'h101));
            end
            if (s == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1 rready_i = 2'b11;
        @(negedge clk);
        tests_run++;
        if ({rvalid_o, rlast_o, ROM_addr_o, rdata_o} !== {2'b01, 2'b00, 12'h102, rom_word(12'h101)}) begin
            tests_failed++;
            $display("FAIL bp_resume: got rvalid=%b rlast=%b addr=%h data=%h, want 01 00 102 %h",
                     rvalid_o, rlast_o, ROM_addr_o, rdata_o, rom_word(12'h101));
        end
        @(negedge clk);
        tests_run++;
        if ({rvalid_o, rlast_o, ROM_addr_o, rdata_o} !== {2'b01, 2'b01, 12'h103, rom_word(12'h102)}) begin
            tests_failed++;
            $display("FAIL bp_last: got rvalid=%b rlast=%b addr=%h data=%h, want 01 01 103 %h",
                     rvalid_o, rlast_o, ROM_addr_o, rdata_o, rom_word(12'h102));
        end
        @(negedge clk);
        tests_run++;
        if ({rvalid_o, ROM_en_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL bp_end: got rvalid=%b en=%b, want 00 0", rvalid_o, ROM_en_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 req_i = 2'b10; addr1_i = 12'h300; len1_i = 4'd5;
        @(negedge clk);
        tests_run++;
        if (gnt_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL mid_grant: got gnt=%b, want 10", gnt_o);
        end
        @(posedge clk); #1 req_i = 2'b00;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rvalid_o, rlast_o, rdata_o} !== {2'b10, 2'b00, rom_word(12'h302)}) begin
            tests_failed++;
            $display("FAIL mid_beat2: got rvalid=%b rlast=%b data=%h, want 10 00 %h",
                     rvalid_o, rlast_o, rdata_o, rom_word(12'h302));
        end
        #1 rst = 1'b0;
        req_i = 2'b11; addr0_i = 12'h050; len0_i = 4'd0; addr1_i = 12'h060; len1_i = 4'd0;
        #1;
        tests_run++;
        if ({gnt_o, rvalid_o, rlast_o, ROM_en_o, ROM_read_o, ROM_addr_o} !== 20'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got gnt=%b rvalid=%b rlast=%b en=%b addr=%h, want all 0",
                     gnt_o, rvalid_o, rlast_o, ROM_en_o, ROM_addr_o);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({gnt_o, ROM_addr_o} !== {2'b01, 12'h050}) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got gnt=%b addr=%h, want 01 050", gnt_o, ROM_addr_o);
        end
        @(posedge clk); #1 req_i = 2'b00;
        @(negedge clk);
        tests_run++;
        if ({rvalid_o, rlast_o, rdata_o} !== {2'b01, 2'b01, rom_word(12'h050)}) begin
            tests_failed++;
            $display("FAIL post_reset_beat: got rvalid=%b rlast=%b data=%h, want 01 01 %h",
                     rvalid_o, rlast_o, rdata_o, rom_word(12'h050));
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int          n;
        logic        own;
        logic [1:0]  bit_v, prev_bit, exp_rv;
        logic [11:0] base;
        logic [3:0]  len;
        @(posedge clk); #1 rst = 1'b0; req_i = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        req_i = 2'b11; addr0_i = 12'h020; len0_i = 4'd1; addr1_i = 12'h040; len1_i = 4'd0;
        prev_bit = 2'b00;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            own   = (g == 1);
            bit_v = own ? 2'b10 : 2'b01;
            base  = own ? 12'h040 : 12'h020;
            len   = own ? 4'd0 : 4'd1;
            n = 0;
            while (gnt_o === 2'b00 && n < 8) begin
                @(negedge clk);
                n++;
            end
`ifdef ROM_ARB_BACK2BACK_EN
            exp_rv = prev_bit;
`else
            exp_rv = 2'b00;
`endif
            tests_run++;
            if ({gnt_o, rvalid_o, ROM_addr_o} !== {bit_v, exp_rv, base}) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got gnt=%b rvalid=%b addr=%h after %0d waits, want %b %b %h",
                         g, gnt_o, rvalid_o, ROM_addr_o, n, bit_v, exp_rv, base);
            end
            if (g == 2) begin
                @(posedge clk); #1 req_i = 2'b00;
            end
            for (int b = 0; b <= int'(len); b++) begin
                @(negedge clk);
                tests_run++;
                if ({rvalid_o, rlast_o, rdata_o} !==
                    {bit_v, (b == int'(len)) ? bit_v : 2'b00, rom_word(base + 12'(b))}) begin
                    tests_failed++;
                    $display("FAIL rr_beat%0d_%0d: got rvalid=%b rlast=%b data=%h, want %b %b %h",
                             g, b, rvalid_o, rlast_o, rdata_o, bit_v,
                             (b == int'(len)) ? bit_v : 2'b00, rom_word(base + 12'(b)));
                end
            end
            prev_bit = bit_v;
        end
        @(negedge clk);
        tests_run++;
        if ({gnt_o, rvalid_o, ROM_en_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rr_end: got gnt=%b rvalid=%b en=%b, want 00 00 0", gnt_o, rvalid_o, ROM_en_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_contention();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
